// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//
// Shares the single SDRAM controller client port among NUM_PORTS (2..4)
// requesters using round-robin arbitration. A winning request is latched
// into the mem_* outputs and held there as one command until the
// controller answers with mem_ready. That pulse is routed back,
// combinationally, to the owning requester only.
//
// Handshake: a requester raises req_rd/req_wr (with addr/data/byte_en
// stable) and holds it until it sees its own req_ready pulse. It drops
// the request on the edge where it samples req_ready. Toward the
// controller, mem_rd/mem_wr are held until the mem_ready pulse and clear
// on that edge. mem_ready seen while idle is ignored.
//
// Ports
//   clk_logic, system_reset    clock, asynchronous active-high reset
//   req_rd/req_wr              per-port request levels
//   req_addr/req_data          per-port packed address / write data
//   req_byte_en                per-port packed byte enables
//   req_q                      read data, broadcast (mem_q passthrough)
//   req_ready                  one-cycle completion pulse to the owner
//   mem_addr/data/byte_en      latched command to the controller
//   mem_rd/mem_wr              command strobes, held until mem_ready
//   mem_q/mem_ready            controller read data / completion pulse
//   grant                      one-hot owner, zero when idle
//   busy                       high while a command is outstanding (FSM state)

module sdram_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 21
) (
  input  logic                            clk_logic,
  input  logic                            system_reset,
  input  logic [NUM_PORTS-1:0]            req_rd,
  input  logic [NUM_PORTS-1:0]            req_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*32-1:0]         req_data,
  input  logic [NUM_PORTS*4-1:0]          req_byte_en,
  output logic [31:0]                     req_q,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [31:0]                     mem_data,
  output logic [3:0]                      mem_byte_en,
  output logic                            mem_rd,
  output logic                            mem_wr,
  input  logic [31:0]                     mem_q,
  input  logic                            mem_ready,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy
);

  // Port indices always fit in two bits (at most four ports).
  localparam int IW = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           last_q, last_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic [3:0]              be_q, be_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;

  // Per-port request fields unpacked into four-entry arrays. Entries for
  // ports that do not exist are tied to zero, so they are never pending.
  logic [ADDR_WIDTH-1:0]   addr_arr [4];
  logic [31:0]             data_arr [4];
  logic [3:0]              be_arr   [4];
  logic [3:0]              rd_arr;
  logic [3:0]              wr_arr;
  logic [3:0]              pend_arr;

  for (genvar g = 0; g < 4; g++) begin : g_unpack
    if (g < NUM_PORTS) begin : g_real
      assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[g] = req_data[g*32 +: 32];
      assign be_arr[g]   = req_byte_en[g*4 +: 4];
      assign rd_arr[g]   = req_rd[g];
      assign wr_arr[g]   = req_wr[g];
    end else begin : g_absent
      assign addr_arr[g] = '0;
      assign data_arr[g] = '0;
      assign be_arr[g]   = '0;
      assign rd_arr[g]   = 1'b0;
      assign wr_arr[g]   = 1'b0;
    end
  end

  assign pend_arr = rd_arr | wr_arr;

  // Round-robin pick: first pending port scanning from last+1 with wrap.
  // sum never exceeds 2*NUM_PORTS-1, so one subtraction is a full modulo.
  logic          sel_found;
  logic [IW-1:0] sel_idx;

  always_comb begin
    int sum;
    logic [IW-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      sum = int'(last_q) + k;
      if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
      cand = sum[IW-1:0];
      if (!sel_found && pend_arr[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          addr_d = addr_arr[sel_idx];
          data_d = data_arr[sel_idx];
          be_d   = be_arr[sel_idx];
          // rd and wr together on one port is treated as a write.
          wr_d   = wr_arr[sel_idx];
          rd_d   = rd_arr[sel_idx] & ~wr_arr[sel_idx];
          for (int i = 0; i < NUM_PORTS; i++) begin
            grant_d[i] = (sel_idx == IW'(i));
          end
          last_d  = sel_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Command fields stay frozen; only completion moves us on.
        if (mem_ready) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_logic or posedge system_reset) begin
    if (system_reset) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NUM_PORTS - 1);
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign busy        = (state_q == ST_BUSY);
  // grant_q is zero whenever idle, so a stray mem_ready produces nothing.
  assign req_ready   = grant_q & {NUM_PORTS{mem_ready & busy}};
  assign req_q       = mem_q;
  assign grant       = grant_q;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign mem_byte_en = be_q;
  assign mem_rd      = rd_q;
  assign mem_wr      = wr_q;

endmodule
